// File: rtl/fft_frame_controller.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_controller
// Purpose  : Frame sequencer for an 8-point radix-2 DIT FFT datapath.
//            Collects 8 complex samples from a valid/ready stream into
//            bit-reversed frame slots and pulses the stage-1 start. It then
//            waits for stage-3 completion under a watchdog, captures the
//            8 results and streams them out in natural bin order.
// Ports    : CLK, nRESET              clock / async active-low reset
//            in_valid/in_ready        sample input handshake
//            in_real/in_image         sample input data
//            fft_start                one-cycle start pulse to stage 1
//            fft_x_real/fft_x_image   registered bit-reversed frame
//            stage3_done              stage-3 result-valid pulse
//            x_stage3_real/_image     stage-3 results, natural order
//            out_valid/out_ready      result output handshake
//            out_real/out_image       result bin data
//            out_index/out_last       bin number / high with bin 7
//            busy                     controller not in LOAD
//            err_timeout              one-cycle watchdog abort pulse
// Revision : 1.0  initial release
// ============================================================================
module fft_frame_controller #(
    parameter int DATA_W  = 12,
    parameter int TIMEOUT = 16
) (
    input  logic                     CLK,
    input  logic                     nRESET,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_real,
    input  logic signed [DATA_W-1:0] in_image,
    output logic                     fft_start,
    output logic signed [DATA_W-1:0] fft_x_real    [0:7],
    output logic signed [DATA_W-1:0] fft_x_image   [0:7],
    input  logic                     stage3_done,
    input  logic signed [DATA_W-1:0] x_stage3_real [0:7],
    input  logic signed [DATA_W-1:0] x_stage3_image[0:7],
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_real,
    output logic signed [DATA_W-1:0] out_image,
    output logic [2:0]               out_index,
    output logic                     out_last,
    output logic                     busy,
    output logic                     err_timeout
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_START  = 2'd1,
        S_WAIT   = 2'd2,
        S_UNLOAD = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [2:0]               r_k;
    logic [2:0]               r_index;
    logic [WD_W-1:0]          r_wd;
    logic                     r_err;
    logic signed [DATA_W-1:0] r_res_real  [0:7];
    logic signed [DATA_W-1:0] r_res_image [0:7];

    logic       w_in_fire;
    logic       w_out_fire;
    logic       w_capture;
    logic       w_timeout_hit;
    logic [2:0] w_slot;

    // Sample k lands in frame slot bitrev3(k).
    assign w_slot = {r_k[0], r_k[1], r_k[2]};

    assign w_in_fire     = in_valid && in_ready;
    assign w_out_fire    = out_valid && out_ready;
    assign w_capture     = (r_state == S_WAIT) && stage3_done;
    // A done arriving on the last watchdog cycle takes priority over abort.
    assign w_timeout_hit = (r_state == S_WAIT) && !stage3_done && (r_wd == WD_LAST);

    // Result mux reads the buffer directly; the buffer only changes on
    // capture, so the output holds while the downstream stalls.
    assign out_real    = r_res_real[r_index];
    assign out_image   = r_res_image[r_index];
    assign out_index   = r_index;
    assign err_timeout = r_err;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        fft_start    = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid && (r_k == 3'd7)) begin
                    w_next_state = S_START;
                end
            end
            S_START: begin
                fft_start    = 1'b1;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (stage3_done) begin
                    w_next_state = S_UNLOAD;
                end else if (r_wd == WD_LAST) begin
                    w_next_state = S_LOAD;
                end
            end
            S_UNLOAD: begin
                out_valid = 1'b1;
                out_last  = (r_index == 3'd7);
                if (out_ready && (r_index == 3'd7)) begin
                    w_next_state = S_LOAD;
                end
            end
            default: begin
                w_next_state = S_LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counters, frame registers and result buffer
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_k     <= 3'd0;
            r_index <= 3'd0;
            r_wd    <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                fft_x_real[i]  <= '0;
                fft_x_image[i] <= '0;
                r_res_real[i]  <= '0;
                r_res_image[i] <= '0;
            end
        end else begin
            r_err <= w_timeout_hit;

            // k wraps from 7 back to 0 on the frame-completing handshake.
            if (w_in_fire) begin
                fft_x_real[w_slot]  <= in_real;
                fft_x_image[w_slot] <= in_image;
                r_k                 <= r_k + 3'd1;
            end

            if (r_state == S_START) begin
                r_wd <= '0;
            end else if (r_state == S_WAIT) begin
                r_wd <= r_wd + WD_W'(1);
            end

            // Index wraps from 7 to 0 when the last bin is taken.
            if (w_capture) begin
                r_index <= 3'd0;
                for (int i = 0; i < 8; i++) begin
                    r_res_real[i]  <= x_stage3_real[i];
                    r_res_image[i] <= x_stage3_image[i];
                end
            end else if (w_out_fire) begin
                r_index <= r_index + 3'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fft_frame_controller
// Purpose  : Self-checking bench for fft_frame_controller. Frames, stub
//            datapath results and expected outputs come from a small
//            reference model (sample arrays + bit-reversal arithmetic).
// Revision : 1.0  initial release
// ============================================================================
module tb_fft_frame_controller;

    localparam int DW = 12;
    localparam int TO = 16;

    logic                 CLK = 1'b0;
    logic                 nRESET = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] in_real = '0;
    logic signed [DW-1:0] in_image = '0;
    logic                 fft_start;
    logic signed [DW-1:0] fft_x_real    [0:7];
    logic signed [DW-1:0] fft_x_image   [0:7];
    logic                 stage3_done = 1'b0;
    logic signed [DW-1:0] x_stage3_real [0:7];
    logic signed [DW-1:0] x_stage3_image[0:7];
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [DW-1:0] out_real;
    logic signed [DW-1:0] out_image;
    logic [2:0]           out_index;
    logic                 out_last;
    logic                 busy;
    logic                 err_timeout;

    fft_frame_controller #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .CLK           (CLK),
        .nRESET        (nRESET),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_real       (in_real),
        .in_image      (in_image),
        .fft_start     (fft_start),
        .fft_x_real    (fft_x_real),
        .fft_x_image   (fft_x_image),
        .stage3_done   (stage3_done),
        .x_stage3_real (x_stage3_real),
        .x_stage3_image(x_stage3_image),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_real      (out_real),
        .out_image     (out_image),
        .out_index     (out_index),
        .out_last      (out_last),
        .busy          (busy),
        .err_timeout   (err_timeout)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: current input frame and current datapath results.
    logic signed [DW-1:0] s_re [8];
    logic signed [DW-1:0] s_im [8];
    logic signed [DW-1:0] r_re [8];
    logic signed [DW-1:0] r_im [8];

    function automatic int bitrev3(input int k);
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic rand_frame();
        for (int k = 0; k < 8; k++) begin
            s_re[k] = DW'($urandom);
            s_im[k] = DW'($urandom);
        end
    endtask

    task automatic rand_results();
        for (int i = 0; i < 8; i++) begin
            r_re[i] = DW'($urandom);
            r_im[i] = DW'($urandom);
        end
    endtask

    task automatic scramble_stage3();
        for (int i = 0; i < 8; i++) begin
            x_stage3_real[i]  = DW'($urandom);
            x_stage3_image[i] = DW'($urandom);
        end
    endtask

    task automatic drive_stage3_model();
        for (int i = 0; i < 8; i++) begin
            x_stage3_real[i]  = r_re[i];
            x_stage3_image[i] = r_im[i];
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_fft_start"}, fft_start, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err_timeout, 0);
        chk({tag, "_out_real"}, out_real, 0);
        chk({tag, "_out_image"}, out_image, 0);
        chk({tag, "_out_index"}, out_index, 0);
        for (int j = 0; j < 8; j++) begin
            chk({tag, "_xr0"}, fft_x_real[j], 0);
            chk({tag, "_xi0"}, fft_x_image[j], 0);
        end
    endtask

    // Slot j of the stage-1 frame must hold the sample whose arrival
    // index is the bit-reversal of j.
    task automatic check_frame(input string tag);
        for (int j = 0; j < 8; j++) begin
            chk({tag, "_xr"}, fft_x_real[j], s_re[bitrev3(j)]);
            chk({tag, "_xi"}, fft_x_image[j], s_im[bitrev3(j)]);
        end
    endtask

    // Feeds s_re/s_im; returns in the START cycle.
    task automatic load_frame(input bit gaps);
        for (int k = 0; k < 8; k++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_real  = s_re[k];
            in_image = s_im[k];
            chk("ld_in_ready", in_ready, 1);
            chk("ld_no_start", fft_start, 0);
            tick();
        end
        in_valid = 1'b0;
        chk("start_pulse", fft_start, 1);
        chk("start_in_ready", in_ready, 0);
        chk("start_busy", busy, 1);
        check_frame("frame");
    endtask

    // From START: stub datapath answers 3 cycles after fft_start.
    task automatic run_datapath();
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("wait_start_low", fft_start, 0);
            chk("wait_no_valid", out_valid, 0);
            chk("wait_in_ready", in_ready, 0);
        end
        stage3_done = 1'b1;
        drive_stage3_model();
        tick();
        stage3_done = 1'b0;
        scramble_stage3();
        chk("unl_valid_rise", out_valid, 1);
        chk("unl_index0", out_index, 0);
        chk("unl_no_err", err_timeout, 0);
    endtask

    task automatic unload(input bit toggle, input bit spur);
        int idx   = 0;
        int guard = 0;
        bit rdy   = 1'b1;
        while (idx < 8 && guard < 100) begin
            chk("u_valid", out_valid, 1);
            chk("u_real", out_real, r_re[idx]);
            chk("u_image", out_image, r_im[idx]);
            chk("u_index", out_index, idx);
            chk("u_last", out_last, (idx == 7) ? 1 : 0);
            chk("u_in_ready", in_ready, 0);
            rdy = toggle ? ~rdy : 1'b1;
            out_ready = rdy;
            if (spur && guard == 1) begin
                stage3_done = 1'b1;
                scramble_stage3();
            end else begin
                stage3_done = 1'b0;
            end
            tick();
            if (rdy) idx++;
            guard++;
        end
        out_ready   = 1'b0;
        stage3_done = 1'b0;
        chk("u_all_bins", idx, 8);
        chk("u_post_valid", out_valid, 0);
        chk("u_post_ready", in_ready, 1);
        chk("u_post_busy", busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            x_stage3_real[i]  = '0;
            x_stage3_image[i] = '0;
        end

        // ---- 1. Reset -------------------------------------------------
        tick();
        tick();
        check_reset_vals("rst_held");
        nRESET = 1'b1;
        tick();
        check_reset_vals("rst_rel");

        rand_frame();
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_real  = s_re[k];
            in_image = s_im[k];
            tick();
        end
        in_valid = 1'b0;
        nRESET = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        #1;
        nRESET = 1'b1;
        tick();
        rand_frame();
        rand_results();
        load_frame(1'b1);
        run_datapath();
        unload(1'b0, 1'b0);

        // ---- 2. Load ordering (real=k, image=-k) ----------------------
        for (int k = 0; k < 8; k++) begin
            s_re[k] = DW'(k);
            s_im[k] = DW'(-k);
        end
        rand_results();
        load_frame(1'b1);
        chk("ord_slot1", fft_x_real[1], 4);
        chk("ord_slot3_im", fft_x_image[3], DW'(-6));

        // ---- 3. Unload with backpressure (10*i, -i) ------------------
        for (int i = 0; i < 8; i++) begin
            r_re[i] = DW'(10 * i);
            r_im[i] = DW'(-i);
        end
        run_datapath();
        unload(1'b1, 1'b1);

        // ---- 5a. Spurious done during LOAD ---------------------------
        stage3_done = 1'b1;
        scramble_stage3();
        tick();
        stage3_done = 1'b0;
        chk("spur_ld_busy", busy, 0);
        chk("spur_ld_ready", in_ready, 1);
        chk("spur_ld_valid", out_valid, 0);
        chk("spur_ld_real", out_real, r_re[0]);
        chk("spur_ld_image", out_image, r_im[0]);
        tick();
        chk("spur_ld_busy2", busy, 0);

        // ---- 4. Timeout ----------------------------------------------
        rand_frame();
        load_frame(1'b0);
        for (int c = 1; c <= TO + 1; c++) begin
            tick();
            chk("to_no_valid", out_valid, 0);
            if (c <= TO) begin
                chk("to_err_early", err_timeout, 0);
                chk("to_busy", busy, 1);
            end else begin
                chk("to_err_pulse", err_timeout, 1);
                chk("to_busy_drop", busy, 0);
                chk("to_in_ready", in_ready, 1);
            end
        end
        tick();
        chk("to_err_one_cycle", err_timeout, 0);
        chk("to_no_valid_after", out_valid, 0);
        check_frame("to_frame_kept");

        // ---- 5b. Done on the last watchdog cycle ----------------------
        rand_frame();
        rand_results();
        load_frame(1'b0);
        for (int c = 1; c <= TO; c++) begin
            tick();
            chk("sim_no_err", err_timeout, 0);
        end
        stage3_done = 1'b1;
        drive_stage3_model();
        tick();
        stage3_done = 1'b0;
        scramble_stage3();
        chk("sim_valid", out_valid, 1);
        chk("sim_err", err_timeout, 0);
        unload(1'b0, 1'b0);

        // ---- 6. Back-to-back frames ----------------------------------
        rand_frame();
        rand_results();
        load_frame(1'b0);
        run_datapath();
        rand_frame();
        in_valid = 1'b1;
        in_real  = s_re[0];
        in_image = s_im[0];
        unload(1'b0, 1'b0);
        rand_results();
        load_frame(1'b0);
        run_datapath();
        unload(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

endmodule
`default_nettype wire
